// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants and helpers for the forwarding/hazard unit.
// Holds the forward-select encoding, latency codes and the priority forward picker.
package hazard_pkg;

   localparam int FSEL_RF  = 0;
   localparam int LAT_ALU  = 0;
   localparam int LAT_LOAD = 1;
   localparam int MAX_FWD  = 32;

   // Bit k of match means stage k+1 holds the operand; the lowest stage (nearest) wins.
   function automatic int prio_sel(input logic [MAX_FWD-1:0] match);
      int sel;
      sel = FSEL_RF;
      for (int k = MAX_FWD - 1; k >= 0; k--) begin
         if (match[k]) begin
            sel = k + 1;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Issue, source, forwarding and result signals of the hazard unit.
// master drives the pipeline-side inputs; slave is the hazard unit itself.
interface fwd_hazard_unit_if
   import hazard_pkg::*;
#(
   parameter int NUM_RD_PORTS   = 2,
   parameter int NUM_FWD_STAGES = 2,
   parameter int REG_ADDR_W     = 5,
   parameter int MAX_LAT        = 3,
   parameter int LAT_W          = $clog2(MAX_LAT + 1),
   parameter int FSEL_W         = $clog2(NUM_FWD_STAGES + 1)
);
   logic                                 issue_valid;
   logic                                 issue_we;
   logic [REG_ADDR_W-1:0]                issue_rd;
   logic [LAT_W-1:0]                     issue_lat;
   logic [NUM_RD_PORTS*REG_ADDR_W-1:0]   id_src;
   logic [NUM_RD_PORTS-1:0]              id_src_used;
   logic [NUM_RD_PORTS*REG_ADDR_W-1:0]   ex_src;
   logic [NUM_FWD_STAGES-1:0]            fwd_we;
   logic [NUM_FWD_STAGES*REG_ADDR_W-1:0] fwd_addr;
   logic [REG_ADDR_W-1:0]                mem_st_src;
   logic                                 stall;
   logic [NUM_RD_PORTS*FSEL_W-1:0]       fwd_sel;
   logic                                 copy_fwd;
   logic [31:0]                          perf_stall_cnt;

   modport master (
      output issue_valid, issue_we, issue_rd, issue_lat,
      output id_src, id_src_used, ex_src,
      output fwd_we, fwd_addr, mem_st_src,
      input  stall, fwd_sel, copy_fwd, perf_stall_cnt
   );

   modport slave (
      input  issue_valid, issue_we, issue_rd, issue_lat,
      input  id_src, id_src_used, ex_src,
      input  fwd_we, fwd_addr, mem_st_src,
      output stall, fwd_sel, copy_fwd, perf_stall_cnt
   );
endinterface

// File: rtl/fwd_hazard_unit_sb_entry.sv
// One register's pending-producer counter: load on issue, count down to zero.
// A load in the same cycle as a decrement wins, so the newest producer is tracked.
module hazard_sb_entry
   import hazard_pkg::*;
#(
   parameter int MAX_LAT = 3,
   parameter int LAT_W   = $clog2(MAX_LAT + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [LAT_W-1:0] i_lat,
   output logic [LAT_W-1:0] o_cnt
);
   logic [LAT_W-1:0] r_cnt;
   logic [LAT_W-1:0] w_lat_sat;

   assign w_lat_sat = (i_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : i_lat;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= w_lat_sat;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - LAT_W'(1);
      end
   end

   assign o_cnt = r_cnt;
endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit beside the ID/EX boundary: latency scoreboard stall,
// priority operand forwarding, store-data copy and a saturating stall counter.
module fwd_hazard_unit
   import hazard_pkg::*;
#(
   parameter int NUM_RD_PORTS   = 2,
   parameter int NUM_FWD_STAGES = 2,
   parameter int REG_ADDR_W     = 5,
   parameter int MAX_LAT        = 3,
   parameter int LAT_W          = $clog2(MAX_LAT + 1),
   parameter int FSEL_W         = $clog2(NUM_FWD_STAGES + 1)
) (
   input  logic             clk,
   input  logic             reset,
   fwd_hazard_unit_if.slave bus
);
   localparam int NUM_REGS = 1 << REG_ADDR_W;
   localparam int LAST     = NUM_FWD_STAGES - 1;

   logic                      w_stall;
   logic                      w_accept;
   logic [NUM_REGS-1:0]       w_pending;
   logic [NUM_RD_PORTS-1:0]   w_port_hit;
   logic [NUM_FWD_STAGES-1:0] w_match [NUM_RD_PORTS];
   logic [REG_ADDR_W-1:0]     w_last_addr;
   logic [31:0]               r_perf_stall_cnt;

   assign w_accept = bus.issue_valid && !w_stall && bus.issue_we && (bus.issue_rd != '0);

   // r0 is hardwired: no counter, never pending.
   assign w_pending[0] = 1'b0;

   generate
      for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_sb
         logic [LAT_W-1:0] w_cnt;

         hazard_sb_entry #(
            .MAX_LAT (MAX_LAT),
            .LAT_W   (LAT_W)
         ) u_entry (
            .clk    (clk),
            .reset  (reset),
            .i_load (w_accept && (bus.issue_rd == REG_ADDR_W'(gi))),
            .i_lat  (bus.issue_lat),
            .o_cnt  (w_cnt)
         );

         assign w_pending[gi] = |w_cnt;
      end

      for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_stall
         assign w_port_hit[gi] = bus.id_src_used[gi] &&
                                 w_pending[bus.id_src[gi*REG_ADDR_W +: REG_ADDR_W]];
      end

      for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_fwd
         for (genvar gj = 0; gj < NUM_FWD_STAGES; gj++) begin : g_stage
            assign w_match[gi][gj] =
               bus.fwd_we[gj] &&
               (bus.fwd_addr[gj*REG_ADDR_W +: REG_ADDR_W] != '0) &&
               (bus.fwd_addr[gj*REG_ADDR_W +: REG_ADDR_W] == bus.ex_src[gi*REG_ADDR_W +: REG_ADDR_W]);
         end

         assign bus.fwd_sel[gi*FSEL_W +: FSEL_W] = FSEL_W'(prio_sel(MAX_FWD'(w_match[gi])));
      end
   endgenerate

   assign w_stall   = bus.issue_valid && (|w_port_hit);
   assign bus.stall = w_stall;

   assign w_last_addr  = bus.fwd_addr[LAST*REG_ADDR_W +: REG_ADDR_W];
   assign bus.copy_fwd = bus.fwd_we[LAST] && (w_last_addr != '0) && (w_last_addr == bus.mem_st_src);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_perf_stall_cnt <= '0;
      end else if (w_stall && (r_perf_stall_cnt != 32'hFFFF_FFFF)) begin
         r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end
   end

   assign bus.perf_stall_cnt = r_perf_stall_cnt;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed plus randomized bench for fwd_hazard_unit, checked against a
// cycle-level model of the scoreboard, forwarding rules and stall counter.
module tb_fwd_hazard_unit;
   import hazard_pkg::*;

   localparam int NRP = 2;
   localparam int NFS = 2;
   localparam int AW  = 5;
   localparam int ML  = 3;
   localparam int LW  = 2;
   localparam int FW  = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fwd_hazard_unit_if #(
      .NUM_RD_PORTS(NRP), .NUM_FWD_STAGES(NFS), .REG_ADDR_W(AW),
      .MAX_LAT(ML), .LAT_W(LW), .FSEL_W(FW)
   ) bus ();

   fwd_hazard_unit #(
      .NUM_RD_PORTS(NRP), .NUM_FWD_STAGES(NFS), .REG_ADDR_W(AW),
      .MAX_LAT(ML), .LAT_W(LW), .FSEL_W(FW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          m_cnt [32];
   logic [31:0] m_perf;
   int          n_pass  = 0;
   int          n_total = 0;

   function automatic logic m_stall();
      int src;
      if (!bus.issue_valid) return 1'b0;
      for (int p = 0; p < NRP; p++) begin
         src = int'(bus.id_src[p*AW +: AW]);
         if (bus.id_src_used[p] && src != 0 && m_cnt[src] > 0) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic int m_fwd(input int p);
      logic [AW-1:0] a;
      logic [AW-1:0] s;
      s = bus.ex_src[p*AW +: AW];
      for (int k = 1; k <= NFS; k++) begin
         a = bus.fwd_addr[(k-1)*AW +: AW];
         if (bus.fwd_we[k-1] && a != '0 && a == s) return k;
      end
      return 0;
   endfunction

   function automatic logic m_copy();
      logic [AW-1:0] a;
      a = bus.fwd_addr[(NFS-1)*AW +: AW];
      return bus.fwd_we[NFS-1] && a != '0 && a == bus.mem_st_src;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".stall"}, 32'(bus.stall), 32'(m_stall()));
      for (int p = 0; p < NRP; p++) begin
         chk($sformatf("%s.fwd_sel%0d", tag, p), 32'(bus.fwd_sel[p*FW +: FW]), 32'(m_fwd(p)));
      end
      chk({tag, ".copy_fwd"}, 32'(bus.copy_fwd), 32'(m_copy()));
      chk({tag, ".perf"}, bus.perf_stall_cnt, m_perf);
   endtask

   // One clock: check outputs mid-cycle, then advance the model on the edge.
   task automatic cycle(input string tag, output logic stalled);
      int rd;
      int lat;
      @(negedge clk);
      stalled = m_stall();
      check_all(tag);
      $display("%0t %s issue_v=%0b rd=%0d lat=%0d stall=%0b perf=%0h",
               $time, tag, bus.issue_valid, bus.issue_rd, bus.issue_lat, stalled, m_perf);
      @(posedge clk);
      for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) m_cnt[r]--;
      rd  = int'(bus.issue_rd);
      lat = int'(bus.issue_lat);
      if (bus.issue_valid && !stalled && bus.issue_we && rd != 0) m_cnt[rd] = (lat > ML) ? ML : lat;
      if (stalled && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 32'd1;
      #1;
   endtask

   task automatic set_idle();
      bus.issue_valid = 1'b0;
      bus.issue_we    = 1'b0;
      bus.issue_rd    = '0;
      bus.issue_lat   = '0;
      bus.id_src      = '0;
      bus.id_src_used = '0;
      bus.ex_src      = '0;
      bus.fwd_we      = '0;
      bus.fwd_addr    = '0;
      bus.mem_st_src  = '0;
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_perf = '0;
   endtask

   task automatic issue(input int rd, input int lat);
      bus.issue_valid = 1'b1;
      bus.issue_we    = 1'b1;
      bus.issue_rd    = AW'(rd);
      bus.issue_lat   = LW'(lat);
      bus.id_src_used = '0;
   endtask

   task automatic consume(input int p, input int src);
      bus.issue_valid = 1'b1;
      bus.issue_we    = 1'b0;
      bus.issue_rd    = '0;
      bus.id_src_used = '0;
      bus.id_src[p*AW +: AW] = AW'(src);
      bus.id_src_used[p] = 1'b1;
   endtask

   // Holds the consumer until it is accepted, counting stalled cycles (bounded).
   task automatic run_until_accept(input string tag, output int n);
      logic s;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         cycle(tag, s);
         if (!s) break;
         n++;
      end
   endtask

   initial begin
      logic s;
      int   n;

      set_idle();
      model_reset();
      reset = 1'b0;
      #12;
      chk("rst.stall", 32'(bus.stall), 32'd0);
      chk("rst.fwd_sel", 32'(bus.fwd_sel), 32'd0);
      chk("rst.copy_fwd", 32'(bus.copy_fwd), 32'd0);
      chk("rst.perf", bus.perf_stall_cnt, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Reset mid-operation clears a pending producer.
      issue(8, 2);
      cycle("r8_issue", s);
      consume(1, 8);
      cycle("r8_use", s);
      chk("r8_use.stalled", 32'(s), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      chk("midrst.stall", 32'(bus.stall), 32'd0);
      chk("midrst.perf", bus.perf_stall_cnt, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      cycle("postrst_use", s);
      chk("postrst.no_stall", 32'(s), 32'd0);

      // Multi-cycle producer: exactly 3 stall cycles.
      issue(3, 3);
      cycle("mc_issue", s);
      consume(0, 3);
      run_until_accept("mc_use", n);
      chk("mc.stall_cycles", 32'(n), 32'd3);
      set_idle();
      cycle("mc_idle", s);
      chk("mc.perf", bus.perf_stall_cnt, 32'd3);

      // Load-use: one stall cycle, then forward from stage 2.
      issue(5, LAT_LOAD);
      cycle("lu_issue", s);
      consume(0, 5);
      run_until_accept("lu_use", n);
      chk("lu.stall_cycles", 32'(n), 32'd1);
      set_idle();
      bus.ex_src[0 +: AW] = AW'(5);
      bus.fwd_we   = 2'b10;
      bus.fwd_addr = {AW'(5), AW'(0)};
      cycle("lu_fwd", s);
      chk("lu.fwd_sel0", 32'(bus.fwd_sel[0 +: FW]), 32'd2);

      // ALU producer: no stall.
      issue(6, LAT_ALU);
      cycle("alu_issue", s);
      consume(0, 6);
      run_until_accept("alu_use", n);
      chk("alu.stall_cycles", 32'(n), 32'd0);

      // Priority and r0.
      set_idle();
      bus.ex_src   = {AW'(7), AW'(0)};
      bus.fwd_we   = 2'b11;
      bus.fwd_addr = {AW'(7), AW'(7)};
      cycle("prio", s);
      chk("prio.fwd_sel1", 32'(bus.fwd_sel[FW +: FW]), 32'd1);
      bus.ex_src   = '0;
      bus.fwd_addr = '0;
      cycle("r0_fwd", s);
      chk("r0.fwd_sel", 32'(bus.fwd_sel), 32'd0);
      issue(0, 3);
      cycle("r0_issue", s);
      consume(0, 0);
      cycle("r0_use", s);
      chk("r0.no_stall", 32'(s), 32'd0);

      // WAW: newer ALU producer replaces the pending latency-3 one.
      issue(9, 3);
      cycle("waw_issue3", s);
      issue(9, LAT_ALU);
      cycle("waw_issue0", s);
      consume(0, 9);
      cycle("waw_use", s);
      chk("waw.no_stall", 32'(s), 32'd0);

      // Unused port does not stall.
      issue(10, 2);
      cycle("unused_issue", s);
      consume(0, 0);
      bus.id_src[AW +: AW] = AW'(10);
      bus.id_src_used = 2'b00;
      cycle("unused_use", s);
      chk("unused.no_stall", 32'(s), 32'd0);

      // Store copy.
      set_idle();
      bus.fwd_we     = 2'b10;
      bus.fwd_addr   = {AW'(12), AW'(0)};
      bus.mem_st_src = AW'(12);
      cycle("copy_on", s);
      chk("copy.on", 32'(bus.copy_fwd), 32'd1);
      bus.fwd_we = 2'b00;
      cycle("copy_off", s);
      chk("copy.off", 32'(bus.copy_fwd), 32'd0);

      // Counter saturation.
      set_idle();
      force dut.r_perf_stall_cnt = 32'hFFFF_FFFD;
      #1;
      release dut.r_perf_stall_cnt;
      m_perf = 32'hFFFF_FFFD;
      issue(4, 3);
      cycle("sat_issue", s);
      consume(0, 4);
      run_until_accept("sat_use", n);
      set_idle();
      cycle("sat_idle", s);
      chk("sat.perf", bus.perf_stall_cnt, 32'hFFFF_FFFF);

      // Randomized traffic over a small register window to create hazards.
      for (int i = 0; i < 300; i++) begin
         bus.issue_valid = ($urandom_range(0, 3) != 0);
         bus.issue_we    = $urandom_range(0, 1) == 1;
         bus.issue_rd    = AW'($urandom_range(0, 7));
         bus.issue_lat   = LW'($urandom_range(0, 3));
         for (int p = 0; p < NRP; p++) begin
            bus.id_src[p*AW +: AW] = AW'($urandom_range(0, 7));
            bus.ex_src[p*AW +: AW] = AW'($urandom_range(0, 7));
         end
         bus.id_src_used = NRP'($urandom_range(0, 3));
         bus.fwd_we      = NFS'($urandom_range(0, 3));
         for (int k = 0; k < NFS; k++) bus.fwd_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
         bus.mem_st_src  = AW'($urandom_range(0, 7));
         cycle($sformatf("rnd%0d", i), s);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard unit for the pipelined MIPS core, sitting beside the ID/EX boundary. It generalises operand forwarding to any number of read ports and forwarding stages. A per-register latency scoreboard raises a stall whenever a source register's producer cannot yet be forwarded, covering load-use and multi-cycle producers. A saturating stall-cycle counter is kept for performance measurement.

## Interface
- `NUM_RD_PORTS`, default 2: source operands per instruction.
- `NUM_FWD_STAGES`, default 2: forwarding stages. Stage 1 is EX/MEM (nearest), stage `NUM_FWD_STAGES` is MEM/WB.
- `REG_ADDR_W`, default 5: register address width.
- `MAX_LAT`, default 3: largest producer latency, in cycles before its result reaches stage 1.
- `LAT_W`, default `$clog2(MAX_LAT+1)`: latency/counter width.
- `FSEL_W`, default `$clog2(NUM_FWD_STAGES+1)`: forward-select width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `issue_valid` in 1: ID holds an instruction. It is accepted into EX when `issue_valid && !stall`.
- `issue_we` in 1: the issuing instruction writes a register.
- `issue_rd` in REG_ADDR_W: destination register of the issuing instruction.
- `issue_lat` in LAT_W: producer latency. 0 = ALU, 1 = load, >1 = multi-cycle.
- `id_src` in NUM_RD_PORTS*REG_ADDR_W: source registers of the ID instruction. Port p is bits [p*REG_ADDR_W +: REG_ADDR_W].
- `id_src_used` in NUM_RD_PORTS: the port's source is actually read.
- `ex_src` in NUM_RD_PORTS*REG_ADDR_W: source registers of the EX instruction.
- `fwd_we` in NUM_FWD_STAGES: stage k writes a register.
- `fwd_addr` in NUM_FWD_STAGES*REG_ADDR_W: stage k destination register.
- `mem_st_src` in REG_ADDR_W: store-data register of the instruction in MEM.
- `stall` out 1: hold IF/ID and insert a bubble into EX.
- `fwd_sel` out NUM_RD_PORTS*FSEL_W: per EX port. 0 = register file, k = stage k.
- `copy_fwd` out 1: forward stage `NUM_FWD_STAGES` data to MEM store data.
- `perf_stall_cnt` out 32: saturating count of stalled issue cycles.

## Operation
- **Scoreboard.** Each register r, for 1..2^REG_ADDR_W-1, has a pending counter `cnt[r]` of LAT_W bits. Register 0 has no storage and always reads 0.
- **Per-clock update.**
  - Every nonzero `cnt[r]` decrements by 1.
  - On an accepted issue with `issue_we=1` and `issue_rd!=0`, `cnt[issue_rd]` loads `issue_lat`.
  - An issue and a decrement on the same register in the same cycle resolve to the issue load (WAW: the newest producer wins).
  - An `issue_lat` value above MAX_LAT saturates to MAX_LAT.
- **Stall.** `stall = issue_valid && OR over p of (id_src_used[p] && id_src[p]!=0 && cnt[id_src[p]]!=0)`.
  - A stall blocks the issue, so the scoreboard is not loaded that cycle.
- **Forwarding.** For each port p, `fwd_sel[p]` is the lowest k with `fwd_we[k] && fwd_addr[k]!=0 && fwd_addr[k]==ex_src[p]`, else 0. The nearest stage has priority.
- **Store copy.** `copy_fwd = fwd_we[last] && fwd_addr[last]!=0 && fwd_addr[last]==mem_st_src`.
- **Performance counter.** `perf_stall_cnt` increments on each clock where `stall=1`, and saturates at 32'hFFFF_FFFF.

## Timing
- **Reset.** While `reset=0`, asynchronously:
  - all `cnt` = 0 and `perf_stall_cnt` = 0;
  - therefore `stall` = 0;
  - `fwd_sel` and `copy_fwd` follow their combinational inputs. With all-zero inputs they are 0.
- **Reset mid-operation** discards all pending producers. The first cycle after release never stalls.
- **Combinational paths.**
  - `stall` is combinational from the registered `cnt` plus `id_src`, `id_src_used` and `issue_valid`.
  - There is no combinational path from `issue_*` (other than `issue_valid`) to `stall`.
- **Stall duration.** A consumer issued directly behind a producer of latency L stalls exactly L cycles:
  - ALU: 0 stall cycles;
  - load: 1 stall cycle;
  - latency-3 op: 3 stall cycles.
- `fwd_sel` and `copy_fwd` are purely combinational, with zero latency.

## Structure
- Shared package `hazard_pkg`:
  - `FSEL_RF = 0` constant;
  - the latency encodings `LAT_ALU = 0`, `LAT_LOAD = 1`;
  - a function computing the priority forward select.
- Sub-module `hazard_sb_entry`: one register's pending counter, with load, decrement, saturate and async reset. It is instantiated once per register in a generate loop.
- Forward-select and stall trees are generate loops in the top module.

## Test plan
- **Reset.** Pre-load cnt[8]=2, assert `reset=0` mid-cycle -> `stall` drops immediately, `perf_stall_cnt`=0. After release, a consumer of r8 issues with no stall.
- **Load-use.** Issue r5 with lat=1, then ID reads r5 on port 0 -> `stall`=1 for exactly 1 cycle, then accepted. EX `fwd_sel[0]`=2 once `fwd_addr[2]`=5 with `fwd_we[2]`=1.
- **Priority and r0.**
  - `fwd_addr[1]`=`fwd_addr[2]`=7, both we=1, `ex_src[1]`=7 -> `fwd_sel[1]`=1.
  - Writes to r0 -> `fwd_sel`=0 and never stall.
- **WAW and unused port.**
  - r9 pending with cnt=3, then an accepted issue of r9 with lat=0 -> cnt[9]=0 next cycle and a consumer does not stall.
  - A stall on port 1 with `id_src_used[1]`=0 -> no stall.
- **Multi-cycle and counter.**
  - lat=3 producer followed by a dependent -> 3 stall cycles, `perf_stall_cnt`=3.
  - Forced near-saturation -> holds at FFFF_FFFF.
- **Store copy.** `fwd_addr[last]`=12, we=1, `mem_st_src`=12 -> `copy_fwd`=1. With we=0 -> `copy_fwd`=0.
